// File: rtl/pipelined_popcnt_accum_pkg.sv
// Shared helpers for the pipelined popcount accumulator: latency and stage placement.
package popcnt_pkg;

    localparam int MIN_ACC_EXTRA = 1;

    function automatic int popcnt_latency(input int order, input int stage_every);
        return (stage_every == 0) ? 1 : ((order - 1) / stage_every) + 1;
    endfunction

    function automatic bit is_stage_level(input int level, input int stage_every);
        return (stage_every != 0) && (level > 0) && ((level % stage_every) == 0);
    endfunction

endpackage

// File: rtl/pipelined_popcnt_accum_tree.sv
// Recursive halving popcount tree; optional register slice after this node's level.
module popcnt_pipe_tree
    import popcnt_pkg::*;
#(
    parameter int ORDER       = 7,
    parameter int STAGE_EVERY = 2,
    parameter int LEVEL       = ORDER
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic [2**LEVEL-1:0]   bits,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic [LEVEL:0]        sum,
    output logic                  out_valid,
    output logic                  out_first,
    output logic                  out_last
);

    localparam bit REG_HERE = (LEVEL < ORDER) && is_stage_level(LEVEL, STAGE_EVERY);

    logic [LEVEL:0] sum_c;
    logic           valid_c;
    logic           first_c;
    logic           last_c;

    if (LEVEL == 0) begin : g_leaf
        assign sum_c   = bits;
        assign valid_c = in_valid;
        assign first_c = in_first;
        assign last_c  = in_last;
    end else begin : g_node
        localparam int HALF = 2**(LEVEL-1);
        logic [LEVEL-1:0] lo_sum;
        logic [LEVEL-1:0] hi_sum;
        logic             hi_valid;
        logic             hi_first;
        logic             hi_last;
        logic             unused_hi;

        popcnt_pipe_tree #(.ORDER(ORDER), .STAGE_EVERY(STAGE_EVERY), .LEVEL(LEVEL-1)) u_lo (
            .clk(clk), .rst_n(rst_n), .advance(advance),
            .bits(bits[HALF-1:0]),
            .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
            .sum(lo_sum), .out_valid(valid_c), .out_first(first_c), .out_last(last_c)
        );

        // Side-band travels only through the low half; the high half's copy is tied off.
        popcnt_pipe_tree #(.ORDER(ORDER), .STAGE_EVERY(STAGE_EVERY), .LEVEL(LEVEL-1)) u_hi (
            .clk(clk), .rst_n(rst_n), .advance(advance),
            .bits(bits[2*HALF-1:HALF]),
            .in_valid(1'b0), .in_first(1'b0), .in_last(1'b0),
            .sum(hi_sum), .out_valid(hi_valid), .out_first(hi_first), .out_last(hi_last)
        );

        assign unused_hi = ^{hi_valid, hi_first, hi_last};
        assign sum_c     = {1'b0, lo_sum} + {1'b0, hi_sum};
    end

    if (REG_HERE) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum       <= '0;
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end else if (advance) begin
                sum       <= sum_c;
                out_valid <= valid_c;
                out_first <= first_c;
                out_last  <= last_c;
            end
        end
    end else begin : g_comb
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst_n, advance};
        assign sum        = sum_c;
        assign out_valid  = valid_c;
        assign out_first  = first_c;
        assign out_last   = last_c;
    end

endmodule

// File: rtl/pipelined_popcnt_accum.sv
// Streaming popcount with per-packet saturating sum and a valid/ready result register.
module pipelined_popcnt_accum
    import popcnt_pkg::*;
#(
    parameter int ORDER       = 7,
    parameter int STAGE_EVERY = 2,
    parameter int ACC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2**ORDER-1:0]   bitset,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  count,
    output logic                  overflow
);

    localparam int EXT_W = ACC_WIDTH + 1;

    if (ACC_WIDTH < ORDER + MIN_ACC_EXTRA) begin : g_width_check
        $error("ACC_WIDTH must be at least ORDER+1");
    end

    logic                 advance;
    logic                 t_valid;
    logic                 t_first;
    logic                 t_last;
    logic [ORDER:0]       t_sum;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf_flag;
    logic [ACC_WIDTH-1:0] base;
    logic [EXT_W-1:0]     ext;
    logic                 saturated;
    logic [ACC_WIDTH-1:0] next_sum;
    logic                 next_ovf;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    popcnt_pipe_tree #(.ORDER(ORDER), .STAGE_EVERY(STAGE_EVERY), .LEVEL(ORDER)) u_tree (
        .clk(clk), .rst_n(rst_n), .advance(advance),
        .bits(bitset),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .sum(t_sum), .out_valid(t_valid), .out_first(t_first), .out_last(t_last)
    );

    always_comb begin
        base      = t_first ? '0 : acc;
        ext       = {1'b0, base} + EXT_W'(t_sum);
        saturated = ext[ACC_WIDTH];
        next_sum  = saturated ? '1 : ext[ACC_WIDTH-1:0];
        next_ovf  = (!t_first && ovf_flag) || saturated;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            ovf_flag  <= 1'b0;
            out_valid <= 1'b0;
            count     <= '0;
            overflow  <= 1'b0;
        end else if (advance) begin
            out_valid <= t_valid && t_last;
            if (t_valid) begin
                if (t_last) begin
                    count    <= next_sum;
                    overflow <= next_ovf;
                    acc      <= '0;
                    ovf_flag <= 1'b0;
                end else begin
                    acc      <= next_sum;
                    ovf_flag <= next_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_popcnt_accum.sv
// Four configurations share one directed stream; a packet-level model checks each cycle.
module tb_pipelined_popcnt_accum;

    localparam int NI = 4;
    localparam int LAT [NI] = '{4, 4, 1, 7};
    localparam int AWS [NI] = '{32, 8, 32, 32};
    localparam int NEXP = 16;
    localparam int unsigned EXPC [NEXP] = '{128, 132, 256, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 10, 20, 30};

    typedef struct packed {
        logic       v;
        logic       f;
        logic       l;
        logic [7:0] pc;
    } beat_t;

    typedef struct packed {
        logic [31:0] c;
        logic        o;
        int          e;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] bitset;
    logic         in_first;
    logic         in_last;
    logic         out_ready;

    logic         drdy [NI];
    logic         dv   [NI];
    logic [31:0]  dc   [NI];
    logic         dovf [NI];
    logic [7:0]   c1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t1_edge = 0;
    int t5_edge = 0;

    beat_t       dl    [NI][8];
    logic        m_ov  [NI];
    logic [63:0] m_cnt [NI];
    logic        m_ovf [NI];
    logic [63:0] m_acc [NI];
    logic        m_of  [NI];

    rec_t lg  [NI][32];
    int   nlg [NI];

    always #5 clk = ~clk;

    pipelined_popcnt_accum #(.ORDER(7), .STAGE_EVERY(2), .ACC_WIDTH(32)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(drdy[0]), .bitset(bitset),
        .in_first(in_first), .in_last(in_last), .out_valid(dv[0]), .out_ready(out_ready),
        .count(dc[0]), .overflow(dovf[0]));

    pipelined_popcnt_accum #(.ORDER(7), .STAGE_EVERY(2), .ACC_WIDTH(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(drdy[1]), .bitset(bitset),
        .in_first(in_first), .in_last(in_last), .out_valid(dv[1]), .out_ready(out_ready),
        .count(c1), .overflow(dovf[1]));
    assign dc[1] = {24'b0, c1};

    pipelined_popcnt_accum #(.ORDER(7), .STAGE_EVERY(0), .ACC_WIDTH(32)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(drdy[2]), .bitset(bitset),
        .in_first(in_first), .in_last(in_last), .out_valid(dv[2]), .out_ready(out_ready),
        .count(dc[2]), .overflow(dovf[2]));

    pipelined_popcnt_accum #(.ORDER(7), .STAGE_EVERY(1), .ACC_WIDTH(32)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(drdy[3]), .bitset(bitset),
        .in_first(in_first), .in_last(in_last), .out_valid(dv[3]), .out_ready(out_ready),
        .count(dc[3]), .overflow(dovf[3]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] ones(input int n);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[k] = 1'b1;
        return r;
    endfunction

    // Model: each beat waits LAT-1 held-on-stall slots, then the packet rules apply.
    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_ov[i] = 1'b0; m_cnt[i] = '0; m_ovf[i] = 1'b0; m_acc[i] = '0; m_of[i] = 1'b0;
            for (int j = 0; j < 8; j++) dl[i][j] = '0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                for (int i = 0; i < NI; i++) begin
                    beat_t       cur;
                    beat_t       b;
                    logic [63:0] s;
                    logic [63:0] mx;
                    logic        sat;
                    logic        o;
                    if (m_ov[i] && !out_ready) continue;
                    cur = {in_valid, in_first, in_last, 8'($countones(bitset))};
                    if (LAT[i] == 1) b = cur;
                    else b = dl[i][LAT[i]-2];
                    for (int j = 7; j >= 1; j--) dl[i][j] = dl[i][j-1];
                    dl[i][0] = cur;
                    m_ov[i] = b.v && b.l;
                    if (b.v) begin
                        s   = (b.f ? 64'd0 : m_acc[i]) + 64'(b.pc);
                        mx  = (64'd1 << AWS[i]) - 64'd1;
                        sat = s > mx;
                        if (sat) s = mx;
                        o   = (!b.f && m_of[i]) || sat;
                        if (b.l) begin
                            m_cnt[i] = s; m_ovf[i] = o; m_acc[i] = '0; m_of[i] = 1'b0;
                        end else begin
                            m_acc[i] = s; m_of[i] = o;
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        for (int i = 0; i < NI; i++) nlg[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("u%0d in_ready", i), 64'(drdy[i]), 64'(!m_ov[i] || out_ready));
                chk($sformatf("u%0d out_valid", i), 64'(dv[i]), 64'(m_ov[i]));
                if (m_ov[i]) begin
                    chk($sformatf("u%0d count", i), 64'(dc[i]), m_cnt[i]);
                    chk($sformatf("u%0d overflow", i), 64'(dovf[i]), 64'(m_ovf[i]));
                end
                if (dv[i] && out_ready && nlg[i] < 32) begin
                    lg[i][nlg[i]] = '{c: dc[i], o: dovf[i], e: cyc + 1};
                    nlg[i] = nlg[i] + 1;
                end
            end
        end
    end

    task automatic beat(input logic [127:0] b, input logic f, input logic l);
        @(posedge clk);
        #1;
        in_valid = 1'b1; bitset = b; in_first = f; in_last = l;
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        in_valid = 1'b0; bitset = '0; in_first = 1'b0; in_last = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; bitset = '0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(dv[0]), 64'd0);
        chk("reset count", 64'(dc[0]), 64'd0);
        chk("reset overflow", 64'(dovf[0]), 64'd0);
        chk("reset in_ready", 64'(drdy[0]), 64'd1);
        rst_n = 1'b1;

        beat('1, 1'b1, 1'b1);
        t1_edge = cyc + 1;
        idle(12);

        beat(ones(4), 1'b1, 1'b0);
        beat('1, 1'b0, 1'b0);
        beat('0, 1'b0, 1'b1);
        idle(12);

        beat('1, 1'b1, 1'b0);
        beat('1, 1'b0, 1'b1);
        beat(ones(2), 1'b1, 1'b1);
        idle(12);

        beat(ones(5), 1'b1, 1'b0);
        beat(ones(6), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(ones(1), 1'b1, 1'b1);
        idle(12);

        for (int k = 0; k < 8; k++) begin
            beat(ones(k), 1'b1, 1'b1);
            if (k == 0) t5_edge = cyc + 1;
        end
        idle(14);

        beat(ones(10), 1'b1, 1'b1);
        beat(ones(20), 1'b1, 1'b1);
        beat(ones(30), 1'b1, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("stall in_ready", 64'(drdy[0]), 64'd0);
            chk("stall count", 64'(dc[0]), 64'd10);
        end
        out_ready = 1'b1;
        idle(14);

        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d results", i), 64'(nlg[i]), 64'(NEXP));
            for (int k = 0; k < NEXP && k < nlg[i]; k++) begin
                logic [31:0] ec;
                logic        eo;
                ec = EXPC[k];
                eo = 1'b0;
                if (i == 1 && k == 2) begin
                    ec = 32'd255;
                    eo = 1'b1;
                end
                chk($sformatf("u%0d log%0d count", i, k), 64'(lg[i][k].c), 64'(ec));
                chk($sformatf("u%0d log%0d ovf", i, k), 64'(lg[i][k].o), 64'(eo));
            end
            if (nlg[i] > 0)
                chk($sformatf("u%0d latency single", i), 64'(lg[i][0].e - t1_edge), 64'(LAT[i]));
            if (nlg[i] >= 13) begin
                chk($sformatf("u%0d latency burst", i), 64'(lg[i][5].e - t5_edge), 64'(LAT[i]));
                for (int k = 5; k < 12; k++)
                    chk($sformatf("u%0d burst gap%0d", i, k), 64'(lg[i][k+1].e - lg[i][k].e), 64'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_popcnt_accum.md
Name: pipelined_popcnt_accum

Overview:
Streaming, pipelined population counter for 2^ORDER-bit bitsets, with a per-packet sum.
- Adder tree: same recursive halving as the combinational counter, with register slices inserted every STAGE_EVERY tree levels.
- Accumulator: sums per-beat counts across a packet delimited by first/last flags; emits one result per packet.
- Sits between bitset producers (e.g. bitset enumeration streams) and result collection, with valid/ready on both sides.

Parameters:
- ORDER, 7: input bitset width is 2^ORDER; tree depth is ORDER adder levels.
- STAGE_EVERY, 2: register after tree level k when k % STAGE_EVERY == 0 and 0 < k < ORDER. A value of 0 means no tree registers.
- ACC_WIDTH, 32: accumulator/result width. Must be >= ORDER+1 (elaboration-time check).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- bitset  in  2^ORDER  bits to count
- in_first  in  1  beat starts a packet
- in_last  in  1  beat ends a packet
- out_valid  out  1  packet result valid
- out_ready  in  1  downstream accepts result
- count  out  ACC_WIDTH  packet popcount sum, saturating
- overflow  out  1  packet sum saturated; qualified by out_valid

Behaviour:
- Reset (async on rst_n low): all stage valid bits 0, accumulator 0, overflow flag 0, out_valid 0, count 0. Values in in-flight beats are discarded.
- advance = !out_valid || out_ready. in_ready = advance (combinational from out_ready). When advance is 0, every pipeline register, including stage valids and first/last side-band, holds.
- Tree registers carry the partial sums plus valid/first/last. Partial sum width at level k is k+1 bits; the final tree sum is ORDER+1 bits.
- Latency L = (STAGE_EVERY == 0 ? 0 : floor((ORDER-1)/STAGE_EVERY)) + 1. For the defaults, L = 4.
  - Timing: a last beat accepted at edge t presents out_valid at edge t+L, provided advance stays 1.
- Accumulator update when a valid beat leaves the tree and advance = 1:
  - base = in_first ? 0 : acc.
  - sum = base + beat_count, saturating at 2^ACC_WIDTH-1.
  - ovf = (in_first ? 0 : ovf_flag) | saturated.
- If the beat is last:
  - count <= sum, overflow <= ovf, out_valid <= 1.
  - acc <= 0 and ovf_flag <= 0, so the next packet starts from 0 even if its first flag is missing.
- If the beat is not last: acc <= sum, ovf_flag <= ovf, and out_valid <= 0 once the previous result has been taken.
- A first flag mid-packet discards the partial sum. A beat with first && last is a single-beat packet.
- out_valid holds, with count and overflow stable, until out_ready. When out_valid && out_ready and no new last beat completes, out_valid drops next edge. A simultaneous new result replaces the old one (full throughput: one packet per cycle).
- Bubbles (in_valid = 0) propagate as invalid stages and never change the accumulator.
- Reset mid-packet loses the partial packet; no output is produced for it.

Decomposition:
- Package popcnt_pkg:
  - function popcnt_latency(order, stage_every);
  - function is_stage_level(level, stage_every);
  - localparam for the minimum ACC_WIDTH check.
- Sub-module popcnt_pipe_tree (ORDER, STAGE_EVERY):
  - recursive, like the combinational counter, taking a level index;
  - registers with enable = advance and async reset;
  - carries valid/first/last side-band alongside the sum.
- The top level holds only the accumulator, saturation logic and output register.

Test Plan:
- Defaults, single beat all-ones with first = last = 1 at edge t, out_ready = 1 -> out_valid at t+4, count = 128, overflow = 0.
- Packet of 3 beats: 0x0F, all-ones, 0 on consecutive cycles -> exactly one out_valid pulse, count = 132, 4 cycles after the third beat.
- out_valid high with out_ready = 0 for 5 cycles -> in_ready = 0, count/overflow stable; release -> next queued result follows, nothing lost or duplicated.
- ACC_WIDTH = 8, two beats of all-ones (128+128) -> count = 255, overflow = 1; next single beat 0x3 -> count = 2, overflow = 0.
- rst_n pulsed low after 2 beats of an unfinished packet, then single beat 0x1 -> out_valid only once, count = 1.
- 8 single-beat packets with popcounts 0..7 on back-to-back cycles, plus STAGE_EVERY = 0 and STAGE_EVERY = 1 variants -> 8 consecutive results 0..7 in order, at latency 1 and 7 respectively.
